// File: rtl/jtbubl_obj_lbuf.sv
// Object line buffer: two 256x8 banks, one drawn while the other is scanned
// out. Scanned pixels are erased behind the beam so the bank comes back clean
// when it is swapped into the draw role. Both banks are cleared after reset.
module jtbubl_obj_lbuf #(
   parameter logic [7:0] BLANK  = 8'hFF,
   parameter logic [3:0] TRANSP = 4'hF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       pxl_cen,
   input  logic       LHBL,
   input  logic [7:0] hcnt,
   input  logic [7:0] wr_addr,
   input  logic [7:0] wr_data,
   input  logic       wr_en,
   output logic       line_start,
   output logic       init_done,
   output logic [7:0] col_addr
);

   typedef enum logic {
      ST_INIT,
      ST_RUN
   } state_t;

   typedef struct packed {
      logic       we;
      logic [7:0] addr;
      logic [7:0] data;
   } wport_t;

   state_t     state_q;
   logic [8:0] cnt_q;
   logic       bank_q;        // 0: bank 0 (A) is front, bank 1 (B) is back
   logic       lhbl_l_q;
   logic       swap_q;
   logic       line_start_q;
   logic       init_done_q;
   logic       rd_pend_q;
   logic       rd_bank_q;
   logic [7:0] rd_addr_q;
   logic [7:0] col_addr_q;

   // NOTE: the banks carry no reset; the INIT sweep clears them instead,
   // which keeps them mappable onto plain block RAM.
   logic [7:0] mem [2][256];

   logic       run;
   logic       init_we;
   logic       swap;
   logic       rd_issue;
   logic       draw_we;
   logic [7:0] rd_data;
   wport_t     wport [2];

   assign run      = (state_q == ST_RUN);
   assign init_we  = (state_q == ST_INIT) && !rst;
   assign swap     = run && pxl_cen && !LHBL && lhbl_l_q;
   assign rd_issue = run && pxl_cen && LHBL;
   // A write landing in the swap cycle would hit the bank that is about to
   // be displayed, so it is dropped.
   assign draw_we  = run && !rst && wr_en && (wr_data[3:0] != TRANSP) && !swap;
   // The read target is registered with its bank so a later swap cannot
   // redirect the pending erase.
   assign rd_data  = mem[rd_bank_q][rd_addr_q];

   // Per-bank write port: init sweep, then erase-after-read, then draw.
   always_comb begin
      for (int b = 0; b < 2; b++) begin
         // NOTE: every field gets a default before the priority chain so no
         // path leaves a latch behind.
         wport[b] = '{we: 1'b0, addr: cnt_q[7:0], data: BLANK};
         if (init_we) begin
            wport[b].we = 1'b1;
         end else if (rd_pend_q && (rd_bank_q == 1'(b))) begin
            wport[b].we   = 1'b1;
            wport[b].addr = rd_addr_q;
         end else if (draw_we && (bank_q != 1'(b))) begin
            wport[b].we   = 1'b1;
            wport[b].addr = wr_addr;
            wport[b].data = wr_data;
         end
      end
   end

   // Bank storage writes.
   always_ff @(posedge clk) begin
      for (int b = 0; b < 2; b++) begin
         if (wport[b].we) mem[b][wport[b].addr] <= wport[b].data;
      end
   end

   // Control: clear sweep, bank swapping, display read and output latch.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_INIT;
         cnt_q        <= '0;
         bank_q       <= 1'b0;
         lhbl_l_q     <= 1'b0;
         swap_q       <= 1'b0;
         line_start_q <= 1'b0;
         init_done_q  <= 1'b0;
         rd_pend_q    <= 1'b0;
         rd_bank_q    <= 1'b0;
         rd_addr_q    <= '0;
         col_addr_q   <= BLANK;
      end else begin
         // NOTE: non-blocking throughout so every register sees the values
         // from before this edge, independent of statement order.
         swap_q       <= swap;
         line_start_q <= swap_q;
         rd_pend_q    <= rd_issue;
         if (pxl_cen) lhbl_l_q <= LHBL;
         case (state_q)
            ST_INIT: begin
               cnt_q <= cnt_q + 9'd1;
               if (cnt_q == 9'd255) begin
                  state_q      <= ST_RUN;
                  init_done_q  <= 1'b1;
                  line_start_q <= 1'b1;
               end
            end
            ST_RUN: begin
               if (swap) bank_q <= ~bank_q;
               if (rd_issue) begin
                  rd_addr_q <= hcnt;
                  rd_bank_q <= bank_q;
               end
               if (rd_pend_q) begin
                  col_addr_q <= rd_data;
               end else if (pxl_cen && !LHBL) begin
                  col_addr_q <= BLANK;
               end
            end
            default: state_q <= ST_INIT;
         endcase
      end
   end

   assign line_start = line_start_q;
   assign init_done  = init_done_q;
   assign col_addr   = col_addr_q;

endmodule

// File: tb/tb_jtbubl_obj_lbuf.sv
// Bench for jtbubl_obj_lbuf: a line-level model of two banks decides what each
// scanned pixel should show; a monitor compares col_addr one clk after every
// pixel enable against the queued expectation.
module tb_jtbubl_obj_lbuf;

   localparam logic [7:0] BLANK  = 8'hFF;
   localparam logic [3:0] TRANSP = 4'hF;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       pxl_cen = 1'b0;
   logic       LHBL = 1'b0;
   logic [7:0] hcnt = '0;
   logic [7:0] wr_addr = '0;
   logic [7:0] wr_data = '0;
   logic       wr_en = 1'b0;
   logic       line_start;
   logic       init_done;
   logic [7:0] col_addr;

   jtbubl_obj_lbuf #(.BLANK(BLANK), .TRANSP(TRANSP)) dut (
      .clk        (clk),
      .rst        (rst),
      .pxl_cen    (pxl_cen),
      .LHBL       (LHBL),
      .hcnt       (hcnt),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .wr_en      (wr_en),
      .line_start (line_start),
      .init_done  (init_done),
      .col_addr   (col_addr)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0] value;
      logic [7:0] pos;
      logic       active;
   } sb_t;

   sb_t        sb[$];
   int         n_checks = 0;
   int         n_pass = 0;

   // Reference: display contents of both banks, which one is in front.
   logic [7:0] ref_mem [2][256];
   int         ref_front;
   logic       ref_lhbl_l;
   int         ls_expected = 0;
   int         ls_seen = 0;
   int         ls_wide = 0;
   logic       ls_prev = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
      pxl_cen = 1'b0;
      wr_en   = 1'b0;
   endtask

   task automatic ref_reset();
      for (int b = 0; b < 2; b++)
         for (int a = 0; a < 256; a++) ref_mem[b][a] = BLANK;
      ref_front  = 0;
      ref_lhbl_l = 1'b0;
   endtask

   // One pixel enable followed by one idle clk; optional draw write alongside.
   task automatic pixel(input logic [7:0] h, input logic lhbl, input logic we = 1'b0,
                        input logic [7:0] wa = 8'h00, input logic [7:0] wd = 8'h00);
      logic is_swap;
      sb_t  e;
      is_swap  = ref_lhbl_l && !lhbl;
      e.pos    = h;
      e.active = lhbl;
      if (lhbl) begin
         e.value = ref_mem[ref_front][h];
         ref_mem[ref_front][h] = BLANK;
      end else begin
         e.value = BLANK;
      end
      if (is_swap) begin
         ref_front = 1 - ref_front;
         ls_expected++;
      end
      ref_lhbl_l = lhbl;
      if (we && !is_swap && wd[3:0] != TRANSP) ref_mem[1 - ref_front][wa] = wd;
      sb.push_back(e);
      pxl_cen = 1'b1; LHBL = lhbl; hcnt = h;
      wr_en = we; wr_addr = wa; wr_data = wd;
      cycle();
      if (is_swap) check("line_start_early", line_start, 1'b0);
      cycle();
      if (is_swap) check("line_start_pulse", line_start, 1'b1);
   endtask

   task automatic draw(input logic [7:0] wa, input logic [7:0] wd);
      if (wd[3:0] != TRANSP) ref_mem[1 - ref_front][wa] = wd;
      wr_en = 1'b1; wr_addr = wa; wr_data = wd;
      cycle();
   endtask

   task automatic rand_draw();
      logic [7:0] d;
      d = 8'($urandom);
      if ($urandom_range(0, 3) == 0) d[3:0] = TRANSP;
      draw(8'($urandom), d);
   endtask

   // Active scan of hcnt 0..width-1, then blanking (swap on the first blank
   // pixel), then random draw writes into the new back bank.
   task automatic line(input int width, input int ndraws);
      for (int h = 0; h < width; h++) pixel(8'(h), 1'b1);
      for (int i = 0; i < 3; i++) pixel(8'($urandom), 1'b0);
      for (int i = 0; i < ndraws; i++) rand_draw();
   endtask

   // Reset pulse, then the clear sweep with junk draw writes that must be ignored.
   task automatic do_reset();
      int bad;
      bad = 0;
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      ref_reset();
      for (int i = 1; i <= 256; i++) begin
         wr_en = 1'b1; wr_addr = 8'($urandom); wr_data = {4'($urandom), 4'($urandom_range(0, 14))};
         @(posedge clk);
         #1;
         wr_en = 1'b0;
         if (i < 256 && init_done !== 1'b0) bad++;
         if (i == 255) check("init_done_255", init_done, 1'b0);
      end
      check("init_done_256", init_done, 1'b1);
      check("init_line_start", line_start, 1'b1);
      check("init_done_early", bad, 0);
      ls_expected++;
   endtask

   // Scoreboard monitor: each pixel enable yields one col_addr check a clk later.
   initial begin
      sb_t e;
      forever begin
         @(posedge clk);
         if (pxl_cen === 1'b1) begin
            @(posedge clk);
            @(negedge clk);
            if (sb.size() == 0) begin
               n_checks++;
               $display("FAIL sb_underflow: got col_addr %0h with no expectation queued", col_addr);
            end else begin
               e = sb.pop_front();
               check($sformatf("%s_h%02h", e.active ? "pix" : "blank", e.pos), col_addr, e.value);
            end
         end
      end
   end

   // line_start pulse counter and width monitor.
   always @(negedge clk) begin
      if (line_start === 1'b1 && !ls_prev) ls_seen++;
      if (line_start === 1'b1 && ls_prev) ls_wide++;
      ls_prev = (line_start === 1'b1);
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      ref_reset();
      do_reset();
      check("reset_col_addr", col_addr, BLANK);

      // Preload both banks with 8'h12, then reset: both must read back blank.
      for (int a = 0; a < 256; a++) draw(8'(a), 8'h12);
      line(256, 0);
      for (int a = 0; a < 256; a++) draw(8'(a), 8'h12);
      do_reset();
      line(256, 0);
      line(256, 0);

      // Opaque vs transparent write, then erase-after-read over two more lines.
      draw(8'h20, 8'h35);
      draw(8'h21, 8'h4F);
      line(256, 0);
      line(256, 0);
      line(256, 0);
      line(256, 0);

      // Overwrite at address 5; write at address 6 in the swap clk is dropped.
      draw(8'h05, 8'h10);
      draw(8'h05, 8'h22);
      for (int h = 0; h < 256; h++) pixel(8'(h), 1'b1);
      pixel(8'h00, 1'b0, 1'b1, 8'h06, 8'h77);
      pixel(8'h00, 1'b0);
      line(256, 0);
      line(256, 0);

      // Randomised lines with partial scan widths and random draws.
      for (int n = 0; n < 8; n++) line($urandom_range(160, 256), 24);
      line(256, 0);
      line(256, 0);

      // Reset in the middle of a scanned line with content in the front bank.
      for (int a = 0; a < 16; a++) draw(8'(a), 8'h5A);
      line(256, 0);
      for (int h = 0; h < 10; h++) pixel(8'(h), 1'b1);
      sb.push_back('{value: BLANK, pos: 8'h0A, active: 1'b1});
      pxl_cen = 1'b1; LHBL = 1'b1; hcnt = 8'h0A;
      cycle();
      do_reset();
      line(256, 0);
      line(256, 0);

      repeat (4) cycle();
      check("sb_drained", sb.size(), 0);
      check("line_start_count", ls_seen, ls_expected);
      check("line_start_width", ls_wide, 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
